// File: rtl/atm_multi_account_ctrl_if.sv
// Front-end <-> ATM controller bundle: card/keypad requests in, balances and status out.
// The locked status line exists only when ATM_LOCKOUT_EN is defined.
interface atm_multi_account_ctrl_if #(
  parameter int ACC_W = 12,
  parameter int PIN_W = 4,
  parameter int BAL_W = 11
);
  logic             cardIn;
  logic [ACC_W-1:0] accNumber;
  logic [PIN_W-1:0] pin;
  logic [2:0]       menuOption;
  logic             opValid;
  logic [BAL_W-1:0] amount;
  logic [ACC_W-1:0] destAccNumber;
  logic [BAL_W-1:0] balance;
  logic [BAL_W-1:0] initialBalance;
  logic [BAL_W-1:0] finalBalance;
  logic             opDone;
  logic             opError;
  logic [2:0]       errCode;
  logic             showBalance;
  logic             sessionActive;
  logic [2:0]       state;
`ifdef ATM_LOCKOUT_EN
  logic             locked;
`endif

  // opValid is a single-cycle request, accepted only while the controller sits in MENU;
  // there is no ready line, so requests in other states are dropped. Each accepted
  // request (and each card insertion) is answered by exactly one opDone or opError pulse.
  modport master (
    output cardIn, accNumber, pin, menuOption, opValid, amount, destAccNumber,
`ifdef ATM_LOCKOUT_EN
    input  locked,
`endif
    input  balance, initialBalance, finalBalance, opDone, opError, errCode,
           showBalance, sessionActive, state
  );

  modport slave (
    input  cardIn, accNumber, pin, menuOption, opValid, amount, destAccNumber,
`ifdef ATM_LOCKOUT_EN
    output locked,
`endif
    output balance, initialBalance, finalBalance, opDone, opError, errCode,
           showBalance, sessionActive, state
  );
endinterface

// File: rtl/atm_multi_account_ctrl.sv
// Multi-account ATM session controller: PIN auth, balance/withdraw/deposit/transfer, idle timeout.
// Define ATM_LOCKOUT_EN to add per-account bad-PIN lockout and the locked status output.
module atm_multi_account_ctrl #(
  parameter int NUM_ACCOUNTS   = 4,
  parameter int ACC_W          = 12,
  parameter int PIN_W          = 4,
  parameter int BAL_W          = 11,
  parameter int INIT_BALANCE   = 500,
  parameter int INIT_PIN       = 9,
  parameter int TIMEOUT_CYCLES = 100
`ifdef ATM_LOCKOUT_EN
  , parameter int MAX_ATTEMPTS = 3
`endif
) (
  input logic                    clk,
  input logic                    rst,
  atm_multi_account_ctrl_if.slave bus
);
  localparam int IDX_W = (NUM_ACCOUNTS > 1) ? $clog2(NUM_ACCOUNTS) : 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE = 3'd0, AUTH = 3'd1, MENU = 3'd2, EXEC = 3'd3} state_e;

  state_e           st;
  logic             card_q;
  logic [IDX_W-1:0] cur_idx;
  logic [2:0]       op_opt;
  logic [BAL_W-1:0] op_amt;
  logic [ACC_W-1:0] op_dst;
  logic [TMR_W-1:0] timer;
  logic [BAL_W-1:0] bal_mem [NUM_ACCOUNTS];

`ifdef ATM_LOCKOUT_EN
  localparam int ATT_W = $clog2(MAX_ATTEMPTS + 1);
  logic [NUM_ACCOUNTS-1:0] lock_bits;
  logic [ATT_W-1:0]        att_cnt [NUM_ACCOUNTS];
`endif

  logic             acc_ok, pin_ok, dst_ok, funds_ok;
  logic [IDX_W-1:0] acc_idx, dst_idx;
  logic [BAL_W-1:0] src_bal, dst_bal;
  logic [BAL_W:0]   dep_sum, xfer_sum;

  // Sums are one bit wider so the carry flags an overflow without touching storage.
  always_comb begin
    acc_ok   = bus.accNumber < ACC_W'(NUM_ACCOUNTS);
    acc_idx  = bus.accNumber[IDX_W-1:0];
    pin_ok   = bus.pin == (PIN_W'(INIT_PIN) ^ bus.accNumber[PIN_W-1:0]);
    src_bal  = bal_mem[cur_idx];
    dst_idx  = op_dst[IDX_W-1:0];
    dst_bal  = bal_mem[dst_idx];
    dst_ok   = (op_dst < ACC_W'(NUM_ACCOUNTS)) && (dst_idx != cur_idx);
    funds_ok = op_amt <= src_bal;
    dep_sum  = {1'b0, src_bal} + {1'b0, op_amt};
    xfer_sum = {1'b0, dst_bal} + {1'b0, op_amt};
  end

  assign bus.state         = st;
  assign bus.sessionActive = (st == MENU) || (st == EXEC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st                 <= IDLE;
      card_q             <= 1'b0;
      cur_idx            <= '0;
      op_opt             <= '0;
      op_amt             <= '0;
      op_dst             <= '0;
      timer              <= '0;
      bus.balance        <= '0;
      bus.initialBalance <= '0;
      bus.finalBalance   <= '0;
      bus.opDone         <= 1'b0;
      bus.opError        <= 1'b0;
      bus.errCode        <= '0;
      bus.showBalance    <= 1'b0;
      for (int i = 0; i < NUM_ACCOUNTS; i++) bal_mem[i] <= BAL_W'(INIT_BALANCE);
`ifdef ATM_LOCKOUT_EN
      lock_bits  <= '0;
      bus.locked <= 1'b0;
      for (int i = 0; i < NUM_ACCOUNTS; i++) att_cnt[i] <= '0;
`endif
    end else begin
      card_q          <= bus.cardIn;
      bus.opDone      <= 1'b0;
      bus.opError     <= 1'b0;
      bus.showBalance <= 1'b0;
      case (st)
        IDLE: if (bus.cardIn && !card_q) st <= AUTH;
        AUTH: begin
          st <= IDLE;
          if (!acc_ok) begin
            bus.opError <= 1'b1;
            bus.errCode <= 3'd1;
          end
`ifdef ATM_LOCKOUT_EN
          else if (lock_bits[acc_idx]) begin
            bus.opError <= 1'b1;
            bus.errCode <= 3'd7;
            bus.locked  <= 1'b1;
          end
`endif
          else if (!pin_ok) begin
            bus.opError <= 1'b1;
            bus.errCode <= 3'd2;
`ifdef ATM_LOCKOUT_EN
            bus.locked <= (att_cnt[acc_idx] == ATT_W'(MAX_ATTEMPTS - 1));
            if (att_cnt[acc_idx] == ATT_W'(MAX_ATTEMPTS - 1)) lock_bits[acc_idx] <= 1'b1;
            att_cnt[acc_idx] <= att_cnt[acc_idx] + ATT_W'(1);
`endif
          end else begin
            bus.opDone <= 1'b1;
            cur_idx    <= acc_idx;
            timer      <= '0;
            st         <= MENU;
`ifdef ATM_LOCKOUT_EN
            att_cnt[acc_idx] <= '0;
            bus.locked       <= 1'b0;
`endif
          end
        end
        // Card removal beats a request; a request beats a timeout expiring the same cycle.
        MENU: begin
          if (!bus.cardIn) begin
            st <= IDLE;
          end else if (bus.opValid) begin
            op_opt <= bus.menuOption;
            op_amt <= bus.amount;
            op_dst <= bus.destAccNumber;
            timer  <= '0;
            st     <= EXEC;
          end else if (timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
            bus.opError <= 1'b1;
            bus.errCode <= 3'd6;
            st          <= IDLE;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        EXEC: begin
          timer <= '0;
          st    <= bus.cardIn ? MENU : IDLE;
          case (op_opt)
            3'd3: begin
              bus.balance     <= src_bal;
              bus.opDone      <= 1'b1;
              bus.showBalance <= 1'b1;
            end
            3'd4, 3'd5: begin
              if (!funds_ok) begin
                bus.opError <= 1'b1;
                bus.errCode <= 3'd3;
              end else begin
                bal_mem[cur_idx] <= src_bal - op_amt;
                bus.balance      <= src_bal - op_amt;
                bus.opDone       <= 1'b1;
                bus.showBalance  <= (op_opt == 3'd5);
              end
            end
            3'd7: begin
              if (dep_sum[BAL_W]) begin
                bus.opError <= 1'b1;
                bus.errCode <= 3'd4;
              end else begin
                bal_mem[cur_idx] <= dep_sum[BAL_W-1:0];
                bus.balance      <= dep_sum[BAL_W-1:0];
                bus.opDone       <= 1'b1;
              end
            end
            3'd6: begin
              if (!dst_ok) begin
                bus.opError <= 1'b1;
                bus.errCode <= 3'd5;
              end else if (!funds_ok) begin
                bus.opError <= 1'b1;
                bus.errCode <= 3'd3;
              end else if (xfer_sum[BAL_W]) begin
                bus.opError <= 1'b1;
                bus.errCode <= 3'd4;
              end else begin
                bal_mem[cur_idx]   <= src_bal - op_amt;
                bal_mem[dst_idx]   <= xfer_sum[BAL_W-1:0];
                bus.balance        <= src_bal - op_amt;
                bus.initialBalance <= dst_bal;
                bus.finalBalance   <= xfer_sum[BAL_W-1:0];
                bus.opDone         <= 1'b1;
              end
            end
            default: begin
              bus.opError <= 1'b1;
              bus.errCode <= 3'd5;
            end
          endcase
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_atm_multi_account_ctrl.sv
// Bench for atm_multi_account_ctrl: directed scenarios then random sessions checked
// against an account-ledger model. Builds with or without ATM_LOCKOUT_EN.
module tb_atm_multi_account_ctrl;
  localparam int NUM   = 4;
  localparam int ACC_W = 12;
  localparam int PIN_W = 4;
  localparam int BAL_W = 11;
  localparam int MAXV  = 2047;
  localparam int TMO   = 100;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  atm_multi_account_ctrl_if #(.ACC_W(ACC_W), .PIN_W(PIN_W), .BAL_W(BAL_W)) bus ();

  atm_multi_account_ctrl #(
    .NUM_ACCOUNTS(NUM), .ACC_W(ACC_W), .PIN_W(PIN_W), .BAL_W(BAL_W),
    .INIT_BALANCE(500), .INIT_PIN(9), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // ledger model
  int mbal [NUM];
  int matt [NUM];
  bit mlock[NUM];
  int e_bal, e_ib, e_fb, e_locked, cur_src;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM; i++) begin
      mbal[i] = 500; matt[i] = 0; mlock[i] = 1'b0;
    end
    e_bal = 0; e_ib = 0; e_fb = 0; e_locked = 0; cur_src = 0;
  endtask

  task automatic model_auth(input int acc, input int pin, output int code);
    code = 0;
    if (acc >= NUM) code = 1;
`ifdef ATM_LOCKOUT_EN
    else if (mlock[acc]) begin code = 7; e_locked = 1; end
`endif
    else if (pin != ((9 ^ acc) & 15)) begin
      code = 2;
`ifdef ATM_LOCKOUT_EN
      matt[acc]++;
      if (matt[acc] >= 3) mlock[acc] = 1'b1;
      e_locked = mlock[acc];
`endif
    end else begin
      cur_src = acc; matt[acc] = 0; e_locked = 0;
    end
  endtask

  task automatic model_op(input int opt, input int amt, input int dest, output int code, output bit show);
    code = 0; show = 1'b0;
    if (opt == 3) begin
      e_bal = mbal[cur_src]; show = 1'b1;
    end else if (opt == 4 || opt == 5) begin
      if (amt > mbal[cur_src]) code = 3;
      else begin mbal[cur_src] -= amt; e_bal = mbal[cur_src]; show = (opt == 5); end
    end else if (opt == 7) begin
      if (mbal[cur_src] + amt > MAXV) code = 4;
      else begin mbal[cur_src] += amt; e_bal = mbal[cur_src]; end
    end else if (opt == 6) begin
      if (dest >= NUM || dest == cur_src) code = 5;
      else if (amt > mbal[cur_src]) code = 3;
      else if (mbal[dest] + amt > MAXV) code = 4;
      else begin
        e_ib = mbal[dest];
        mbal[cur_src] -= amt; mbal[dest] += amt;
        e_fb = mbal[dest]; e_bal = mbal[cur_src];
      end
    end else code = 5;
  endtask

  // Waits (bounded) for the status pulse, then compares every visible output.
  task automatic check_result(input string tag, input int code, input bit show, input int exp_state);
    bit seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      if (bus.opDone === 1'b1 || bus.opError === 1'b1) seen = 1'b1;
    end
    chk({tag, "_seen"}, seen, 1);
    chk({tag, "_done"}, bus.opDone, code == 0);
    chk({tag, "_error"}, bus.opError, code != 0);
    if (code != 0) chk({tag, "_errcode"}, bus.errCode, code);
    chk({tag, "_show"}, bus.showBalance, show);
    chk({tag, "_balance"}, bus.balance, e_bal);
    chk({tag, "_initial"}, bus.initialBalance, e_ib);
    chk({tag, "_final"}, bus.finalBalance, e_fb);
    chk({tag, "_state"}, bus.state, exp_state);
`ifdef ATM_LOCKOUT_EN
    chk({tag, "_locked"}, bus.locked, e_locked);
`endif
  endtask

  // driver tasks
  task automatic session(input int acc, input int pin, input string tag);
    int code;
    bus.cardIn  = 1'b0;
    bus.opValid = 1'b0;
    repeat (2) @(negedge clk);
    bus.accNumber = ACC_W'(acc);
    bus.pin       = PIN_W'(pin);
    bus.cardIn    = 1'b1;
    model_auth(acc, pin, code);
    check_result(tag, code, 1'b0, (code == 0) ? 2 : 0);
  endtask

  task automatic run_op(input int opt, input int amt, input int dest, input string tag);
    int code; bit show;
    bus.menuOption    = 3'(opt);
    bus.amount        = BAL_W'(amt);
    bus.destAccNumber = ACC_W'(dest);
    bus.opValid       = 1'b1;
    @(negedge clk);
    bus.opValid = 1'b0;
    model_op(opt, amt, dest, code, show);
    check_result(tag, code, show, 2);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    bus.cardIn = 1'b0; bus.opValid = 1'b0; bus.accNumber = '0; bus.pin = '0;
    bus.menuOption = '0; bus.amount = '0; bus.destAccNumber = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, acc, pin, opt, amt, dest, sel, nops;
    bit seen;

    apply_reset();
    chk("rst_state", bus.state, 0);
    chk("rst_active", bus.sessionActive, 0);
    chk("rst_balance", bus.balance, 0);
    chk("rst_initial", bus.initialBalance, 0);
    chk("rst_final", bus.finalBalance, 0);
    chk("rst_done", bus.opDone, 0);
    chk("rst_error", bus.opError, 0);
    chk("rst_errcode", bus.errCode, 0);
    chk("rst_show", bus.showBalance, 0);
`ifdef ATM_LOCKOUT_EN
    chk("rst_locked", bus.locked, 0);
`endif

    // single-account operations
    session(2, 4'b1011, "auth_acc2");
    chk("auth_active", bus.sessionActive, 1);
    run_op(3, 0, 0, "balance");
    chk("balance_500", bus.balance, 500);
    run_op(4, 62, 0, "wd62");
    chk("wd62_438", bus.balance, 438);
    run_op(4, 600, 0, "wd600");
    run_op(7, 1609, 0, "dep1609");
    chk("dep_fullscale", bus.balance, 2047);
    run_op(7, 1, 0, "dep_ovf");
    run_op(1, 5, 0, "opt1");
    run_op(0, 5, 0, "opt0");
    run_op(5, 47, 0, "wd_show");

    // transfers
    session(3, 4'b1010, "auth_acc3");
    run_op(6, 99, 0, "xfer");
    chk("xfer_src", bus.balance, 401);
    chk("xfer_init", bus.initialBalance, 500);
    chk("xfer_final", bus.finalBalance, 599);
    run_op(6, 10, 3, "xfer_self");
    run_op(6, 10, 4, "xfer_baddest");
    run_op(6, 402, 1, "xfer_funds");

    // card pulled in MENU: quiet logout
    bus.cardIn = 1'b0;
    @(negedge clk);
    chk("pull_state", bus.state, 0);
    chk("pull_error", bus.opError, 0);

    // bad account number
    session(4, 0, "bad_acc");

    // idle timeout, expected exactly TIMEOUT_CYCLES cycles after entering MENU
    session(0, 9, "auth_tmo");
    n = 0; seen = 1'b0;
    for (int i = 0; i < 150 && !seen; i++) begin
      @(negedge clk);
      n++;
      if (bus.opError === 1'b1 || bus.opDone === 1'b1) seen = 1'b1;
    end
    chk("tmo_seen", seen, 1);
    chk("tmo_cycles", n, TMO);
    chk("tmo_errcode", bus.errCode, 6);
    chk("tmo_state", bus.state, 0);

    // request on the expiry cycle wins
    session(0, 9, "auth_tmo2");
    repeat (TMO - 1) @(negedge clk);
    run_op(3, 0, 0, "tmo_race");

    // asynchronous reset mid-session
    run_op(4, 100, 0, "pre_abort");
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_state", bus.state, 0);
    chk("abort_balance", bus.balance, 0);
    @(negedge clk);
    rst = 1'b0;
    bus.cardIn = 1'b0;
    model_reset();
    session(0, 9, "auth_after_abort");
    run_op(3, 0, 0, "bal_after_abort");
    chk("abort_restore", bus.balance, 500);

    // repeated bad PINs on account 1
    apply_reset();
    session(1, 0, "badpin1");
    session(1, 3, "badpin2");
    session(1, 15, "badpin3");
    session(1, 4'b1000, "pin_after_3");
`ifdef ATM_LOCKOUT_EN
    chk("lock_code", bus.errCode, 7);
    chk("lock_flag", bus.locked, 1);
`else
    chk("nolock_done", bus.opDone, 1);
`endif

    // randomized sessions against the ledger model
    apply_reset();
    for (int s = 0; s < 30; s++) begin
      acc = $urandom_range(0, NUM);
      pin = ($urandom_range(0, 7) == 0 || acc >= NUM) ? $urandom_range(0, 15) : ((9 ^ acc) & 15);
      session(acc, pin, "rnd_auth");
      if (bus.state == 3'd2) begin
        nops = $urandom_range(1, 6);
        for (int k = 0; k < nops; k++) begin
          opt  = $urandom_range(0, 7);
          dest = $urandom_range(0, NUM);
          sel  = $urandom_range(0, 4);
          case (sel)
            0: amt = $urandom_range(0, 100);
            1: amt = $urandom_range(0, MAXV);
            2: amt = mbal[cur_src];
            3: amt = MAXV - mbal[cur_src];
            default: amt = MAXV - mbal[cur_src] + 1;
          endcase
          if (amt > MAXV) amt = MAXV;
          run_op(opt, amt, dest, "rnd_op");
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
